riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
// - Shares one external single-port memory bus between the core's instruction-fetch and data ports.
// - Sits between the 5-stage riscv core and the memory/bus.
// - Generates the core's I_stall whenever a fetch or data access is still outstanding.
// - Data has priority, with an anti-starvation limit.
// - A watchdog counter bounds every bus transaction.
// PARAMETERS
// - MAX_DATA_RUN  4    consecutive data grants allowed while a fetch waits, before one fetch is forced
// - TIMEOUT       255  cycles a request may wait for I_mem_ack before it is aborted (8-bit counter)
// PORTS
// - I_clk         in   1   clock
// - I_rst         in   1   reset, synchronous, active-high
// - I_imem_addr   in   32  core fetch address (PC)
// - O_imem_data   out  32  fetched instruction; holds the last completed fetch
// - I_dmem_addr   in   32  core data address
// - I_dmem_wdata  in   32  core store data
// - I_dmem_wmask  in   4   byte enables for stores
// - I_dmem_rd     in   1   load request (level)
// - I_dmem_we     in   1   store request (level)
// - O_dmem_rdata  out  32  load data; holds the last completed load
// - O_stall       out  1   stall to core (combinational)
// - O_mem_req     out  1   bus request; held until ack
// - O_mem_addr    out  32  bus address, word aligned ([1:0]=0)
// - O_mem_wdata   out  32  bus write data
// - O_mem_wmask   out  4   bus byte enables (0000 on reads)
// - O_mem_we      out  1   bus write
// - I_mem_ack     in   1   transaction completes in any cycle where O_mem_req && I_mem_ack
// - I_mem_rdata   in   32  read data, valid with I_mem_ack
// - O_bus_err     out  1   one-cycle pulse on watchdog abort
// BEHAVIOUR
// - Reset values:
//   - All outputs 0; state IDLE.
//   - fetch_valid=0, data_done=0, data_run=0, wdog=0.
// - fetch_pend = !fetch_valid || (I_imem_addr != fetch_addr_q).
// - data_pend = (I_dmem_rd || I_dmem_we) && !data_done.
// - O_stall = fetch_pend || data_pend; it is also 1 while state != IDLE.
// - FSM IDLE / DATA / FETCH:
//   - IDLE -> DATA if data_pend && !(fetch_pend && data_run==MAX_DATA_RUN).
//   - IDLE -> FETCH if fetch_pend and DATA is not taken.
//   - Otherwise stay in IDLE.
//   - The bus fields are registered on entry, so minimum latency is request -> O_mem_req in 1 cycle.
//   - DATA/FETCH -> IDLE on ack or timeout.
// - Bus handshake:
//   - O_mem_req and all O_mem_* fields stay stable from assertion until the ack cycle.
//   - O_mem_req deasserts the cycle after ack.
//   - There are no back-to-back requests; IDLE lasts at least 1 cycle.
// - DATA completion:
//   - A load registers O_dmem_rdata <= I_mem_rdata.
//   - data_done <= 1; data_run += 1, saturating at MAX_DATA_RUN.
//   - O_mem_we = I_dmem_we; I_dmem_we has priority if both rd and we are set.
// - FETCH completion:
//   - O_imem_data <= I_mem_rdata; fetch_addr_q <= latched addr; fetch_valid <= 1.
//   - data_run <= 0.
// - data_done clears on the first cycle with O_stall==0, when the core advances.
//   - Exactly one bus access per core memory instruction.
// - Watchdog:
//   - wdog counts while O_mem_req && !I_mem_ack; it clears on entry to DATA/FETCH.
//   - At wdog==TIMEOUT: drop the request, O_bus_err=1 for that cycle, complete as if acked with rdata 32'h0.
//   - A fetch abort loads 32'h00000013 (NOP), so the core cannot execute garbage.
// - Simultaneous events:
//   - PC change during a fetch: the in-flight fetch finishes; the new address stays pending, stall held.
//   - A data request arriving during a fetch waits for it.
// - Reset mid-transaction: O_mem_req drops the next edge; any late I_mem_ack is ignored in IDLE.
// - Address width: all 32 bits are compared for fetch_pend; bits [1:0] of the bus address are forced to 0.
// STRUCTURE
// - Package riscv_pkg holds:
//   - state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_FETCH=2'd2.
//   - NOP_INSTR=32'h00000013.
//   - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011.
// - One sub-module, riscv_bus_watchdog: counter plus timeout flag (clear, run, timeout).
// TESTING
// - Reset then idle bus with ack tied 1 cycle after req:
//   - first fetch at 0x0 -> O_mem_req the cycle after reset.
//   - O_stall=1 for 3 cycles, then O_imem_data=bus word.
// - Store SW at 0x100 with wmask 1111, data 0xDEADBEEF while fetch is pending:
//   - the DATA grant goes first with O_mem_we=1; fetch follows; exactly one store on the bus.
// - 6 consecutive loads with a fetch pending, MAX_DATA_RUN=4 -> grant order D,D,D,D,F,D,D.
// - Ack never arrives, TIMEOUT=255:
//   - O_bus_err pulses exactly 256 cycles after req.
//   - O_imem_data=0x00000013; O_stall clears.
// - PC changes 0x8 -> 0x40 while the 0x8 fetch is in flight:
//   - 0x8 completes, then a second bus read of 0x40.
//   - O_stall stays 1 until the 0x40 data is registered.
// - I_rst asserted during a DATA request -> O_mem_req=0 next cycle; a late ack causes no O_dmem_rdata change.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings and constants for the riscv core and its memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory/bus fabric (slave).
interface riscv_mem_arbiter_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        we;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, wdata, wmask, we, input ack, rdata);
    modport slave  (input req, addr, wdata, wmask, we, output ack, rdata);

endinterface

// File: rtl/riscv_bus_watchdog.sv
// Cycle counter bounding how long a bus request may wait for its acknowledge.
module riscv_bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    logic [7:0] cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign timeout = (cnt == 8'(TIMEOUT));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// data first with a bounded run, and stalls the core until its accesses complete.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic [31:0]                I_imem_addr,
    output logic [31:0]                O_imem_data,
    input  logic [31:0]                I_dmem_addr,
    input  logic [31:0]                I_dmem_wdata,
    input  logic [3:0]                 I_dmem_wmask,
    input  logic                       I_dmem_rd,
    input  logic                       I_dmem_we,
    output logic [31:0]                O_dmem_rdata,
    output logic                       O_stall,
    riscv_mem_arbiter_if.master        mem,
    output logic                       O_bus_err
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_W'(MAX_DATA_RUN)) ? v : v + RUN_W'(1);
    endfunction

    arb_state_e        state, state_nxt;
    logic              fetch_valid;
    logic [31:0]       fetch_addr_q;
    logic [31:0]       fetch_addr_lat;
    logic              data_done;
    logic [RUN_W-1:0]  data_run;
    logic              fetch_pend, data_pend, run_full;
    logic              take_data, take_fetch;
    logic              timeout, done;

    assign fetch_pend = !fetch_valid || (I_imem_addr != fetch_addr_q);
    assign data_pend  = (I_dmem_rd || I_dmem_we) && !data_done;
    assign run_full   = (data_run == RUN_W'(MAX_DATA_RUN));
    assign O_stall    = !I_rst && (fetch_pend || data_pend || (state != ST_IDLE));
    assign mem.req    = (state != ST_IDLE);
    assign done       = mem.req && (mem.ack || timeout);

    riscv_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .clear   (state == ST_IDLE),
        .run     (mem.req && !mem.ack),
        .timeout (timeout)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A fetch that has waited behind a full data run goes first; otherwise data wins.
    always_comb begin
        state_nxt  = state;
        take_data  = 1'b0;
        take_fetch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_pend && !(fetch_pend && run_full)) begin
                    state_nxt = ST_DATA;
                    take_data = 1'b1;
                end else if (fetch_pend) begin
                    state_nxt  = ST_FETCH;
                    take_fetch = 1'b1;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus fields are captured once on grant and held until the transaction ends.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mem.addr       <= '0;
            mem.wdata      <= '0;
            mem.wmask      <= '0;
            mem.we         <= 1'b0;
            fetch_addr_lat <= '0;
        end else if (take_data) begin
            mem.addr  <= word_align(I_dmem_addr);
            mem.wdata <= I_dmem_we ? I_dmem_wdata : 32'h0;
            mem.wmask <= I_dmem_we ? I_dmem_wmask : 4'b0000;
            mem.we    <= I_dmem_we;
        end else if (take_fetch) begin
            mem.addr       <= word_align(I_imem_addr);
            mem.wdata      <= '0;
            mem.wmask      <= '0;
            mem.we         <= 1'b0;
            fetch_addr_lat <= I_imem_addr;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_valid  <= 1'b0;
            fetch_addr_q <= '0;
            O_imem_data  <= '0;
            O_dmem_rdata <= '0;
            data_done    <= 1'b0;
            data_run     <= '0;
            O_bus_err    <= 1'b0;
        end else begin
            O_bus_err <= done && timeout && !mem.ack;
            // The core advances on a stall-free cycle; its next memory op is a new one.
            if (!O_stall) data_done <= 1'b0;
            if (done && (state == ST_DATA)) begin
                if (!mem.we) O_dmem_rdata <= mem.ack ? mem.rdata : 32'h0;
                data_done <= 1'b1;
                data_run  <= sat_inc(data_run);
            end
            if (done && (state == ST_FETCH)) begin
                O_imem_data  <= mem.ack ? mem.rdata : NOP_INSTR;
                fetch_addr_q <= fetch_addr_lat;
                fetch_valid  <= 1'b1;
                data_run     <= '0;
            end
        end
    end

endmodule
